// File: rtl/mpc_vsub_row1_stream.sv
// mpc_vsub_row1_stream
//   Consumes the row-1 constraint-vector ROM. Each run reads d[0..N-1] and pairs
//   each entry with one streamed product element g[i]. It emits r[i] = d[i] - g[i]
//   on a valid/ready stream, flags negative residuals, and pulses done on the
//   handshake of the last residual.
//
//   Build option: define VSUB_SAT_EN to saturate out-of-range differences.
//   When it is undefined, the difference wraps to DW bits.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               run request (ignored while busy)
//   busy, done          run in progress / one-cycle pulse on the last handshake
//   any_viol            sticky OR of residual sign bits for the current run
//   rom_address0/ce0    ROM read port; rom_q0 returns data one cycle after ce0
//   s_data/valid/ready  product element input stream
//   m_data/valid/ready  residual output stream
//   m_neg, m_last       residual sign and last-element flag, qualified by m_valid
module mpc_vsub_row1_stream #(
  parameter int unsigned N  = 6,
  parameter int unsigned DW = 18,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          any_viol,
  output logic [AW-1:0] rom_address0,
  output logic          rom_ce0,
  input  logic [DW-1:0] rom_q0,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_neg,
  output logic          m_last
);

  // One extra index bit so that idx == N is representable even when N == 2**AW.
  localparam int unsigned IW = AW + 1;
  localparam logic [IW-1:0] NumEl   = IW'(N);
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   idx1_q, idx1_d;
  logic            p1_q, p1_d;
  logic [DW-1:0]   g1_q, g1_d;
  logic [DW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic            neg_q, neg_d;
  logic            last_q, last_d;
  logic            viol_q, viol_d;

  logic            accept, load, out_hs;
  logic [DW:0]     diff;
  logic [DW-1:0]   res;

  // Sign-extended subtraction; the extra bit shows whether the result overflows.
  assign diff = {rom_q0[DW-1], rom_q0} - {g1_q[DW-1], g1_q};

  always_comb begin
`ifdef VSUB_SAT_EN
    if (diff[DW] != diff[DW-1]) begin
      res = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      res = diff[DW-1:0];
    end
`else
    res = diff[DW-1:0];
`endif
  end

  always_comb begin
    busy         = (state_q == StRun);
    // Stage 1 must be empty or draining into the output register this cycle.
    s_ready      = busy && (idx_q < NumEl) && (!p1_q || !valid_q || m_ready);
    accept       = s_valid && s_ready;
    // Gating ce0 keeps rom_q0 steady while stage 1 is stalled.
    rom_ce0      = accept;
    rom_address0 = idx_q[AW-1:0];
    load         = p1_q && (!valid_q || m_ready);
    out_hs       = valid_q && m_ready;
    done         = busy && out_hs && last_q;
    m_data       = data_q;
    m_valid      = valid_q;
    m_neg        = neg_q;
    m_last       = last_q;
    any_viol     = viol_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    idx1_d  = idx1_q;
    p1_d    = p1_q;
    g1_d    = g1_q;
    data_d  = data_q;
    valid_d = valid_q;
    neg_d   = neg_q;
    last_d  = last_q;
    viol_d  = viol_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          idx_d   = '0;
          viol_d  = 1'b0;
        end
      end
      StRun: begin
        if (done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      idx_d  = idx_q + 1'b1;
      idx1_d = idx_q;
      g1_d   = s_data;
      p1_d   = 1'b1;
    end else if (load) begin
      p1_d   = 1'b0;
    end

    if (load) begin
      data_d  = res;
      neg_d   = res[DW-1];
      last_d  = (idx1_q == LastIdx);
      valid_d = 1'b1;
      viol_d  = viol_q | res[DW-1];
    end else if (out_hs) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      idx1_q  <= '0;
      p1_q    <= 1'b0;
      g1_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      neg_q   <= 1'b0;
      last_q  <= 1'b0;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      idx1_q  <= idx1_d;
      p1_q    <= p1_d;
      g1_q    <= g1_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      neg_q   <= neg_d;
      last_q  <= last_d;
      viol_q  <= viol_d;
    end
  end

endmodule

// File: tb/tb_mpc_vsub_row1_stream.sv
// Scoreboard bench for mpc_vsub_row1_stream. Accepted inputs push an expected residual
// computed with integer arithmetic; an output monitor pops and compares on handshakes.
module tb_mpc_vsub_row1_stream;
  localparam int N  = 6;
  localparam int DW = 18;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done, any_viol;
  logic [AW-1:0] rom_address0;
  logic          rom_ce0;
  logic [DW-1:0] rom_q0 = '0;
  logic [DW-1:0] s_data;
  logic          s_valid, s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready, m_neg, m_last;

  always #5 clk = ~clk;

  mpc_vsub_row1_stream #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .any_viol(any_viol), .rom_address0(rom_address0), .rom_ce0(rom_ce0),
    .rom_q0(rom_q0), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_neg(m_neg),
    .m_last(m_last)
  );

  // ROM with one-cycle registered latency; q only updates when ce is high.
  logic [DW-1:0] rom_mem [2**AW];
  always @(posedge clk) if (rom_ce0) rom_q0 <= rom_mem[rom_address0];

  typedef struct packed {
    logic [DW-1:0] r;
    logic          neg;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          in_e, out_e;
  int            n_checks = 0, n_fail = 0;
  int            cyc = 0, acc_k = 0, acc_cyc = 0, done_cnt = 0;
  bit            seen_first = 1'b0;
  logic          viol_exp = 1'b0;
  bit            hold = 1'b0;
  logic [DW-1:0] hold_data;
  logic          hold_neg, hold_last;
  logic [DW-1:0] gtab [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: true signed difference, then saturate or wrap to DW bits.
  function automatic exp_t model(input logic [DW-1:0] d, input logic [DW-1:0] g, input int k);
    exp_t   e;
    longint dv, gv, diff;
    dv   = longint'($signed(d));
    gv   = longint'($signed(g));
    diff = dv - gv;
`ifdef VSUB_SAT_EN
    if (diff > (longint'(1) <<< (DW - 1)) - 1) diff = (longint'(1) <<< (DW - 1)) - 1;
    if (diff < -(longint'(1) <<< (DW - 1)))    diff = -(longint'(1) <<< (DW - 1));
`endif
    e.r    = diff[DW-1:0];
    e.neg  = e.r[DW-1];
    e.last = (k == N - 1);
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Input-side monitor: records each accepted element into the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      check("rom_ce0", {63'd0, rom_ce0}, {63'd0, s_valid && s_ready});
      if (s_valid && s_ready) begin
        check("rom_addr", {61'd0, rom_address0}, 64'(acc_k));
        check("accept_within_n", {63'd0, acc_k < N}, 64'd1);
        if (acc_k < N) begin
          in_e = model(rom_mem[acc_k], s_data, acc_k);
          exp_q.push_back(in_e);
          viol_exp = viol_exp | in_e.neg;
          if (acc_k == 0) acc_cyc = cyc;
        end
        acc_k++;
      end
    end
  end

  // Output-side monitor: compares on every handshake and checks hold stability.
  always @(negedge clk) begin
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (hold) begin
        check("hold_valid", {63'd0, m_valid}, 64'd1);
        check("hold_data", {46'd0, m_data}, {46'd0, hold_data});
        check("hold_neg", {63'd0, m_neg}, {63'd0, hold_neg});
        check("hold_last", {63'd0, m_last}, {63'd0, hold_last});
      end
      if (m_valid && !seen_first) begin
        seen_first = 1'b1;
        check("latency", 64'(cyc - acc_cyc), 64'd2);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got 0x%0h, expected none", m_data);
        end else begin
          out_e = exp_q.pop_front();
          check("m_data", {46'd0, m_data}, {46'd0, out_e.r});
          check("m_neg", {63'd0, m_neg}, {63'd0, out_e.neg});
          check("m_last", {63'd0, m_last}, {63'd0, out_e.last});
          check("done", {63'd0, done}, {63'd0, out_e.last});
        end
      end else begin
        check("no_done", {63'd0, done}, 64'd0);
      end
      hold      = m_valid && !m_ready;
      hold_data = m_data;
      hold_neg  = m_neg;
      hold_last = m_last;
    end
  end

  // mode 0: flow; mode 1: random valid/ready; mode 2: 5-cycle ready stall.
  // gmode 0: g=0; 1: gtab; 2: random with extremes.
  task automatic do_run(input int mode, input int gmode, input int reset_at, input bit extra_start);
    int t, dcnt0;
    bit aborted;
    t = 0; aborted = 1'b0;
    acc_k = 0; viol_exp = 1'b0; seen_first = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    dcnt0 = done_cnt;
    while (done_cnt == dcnt0 && t < 300) begin
      if (mode == 2 && t >= 5 && t <= 7) begin
        check("stall_s_ready", {63'd0, s_ready}, 64'd0);
        check("stall_rom_ce0", {63'd0, rom_ce0}, 64'd0);
      end
      if (reset_at >= 0 && acc_k == reset_at) begin
        reset = 1'b1; s_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_m_data", {46'd0, m_data}, 64'd0);
        check("rst_flags", {60'd0, any_viol, m_neg, m_last, done}, 64'd0);
        check("rst_rom", {60'd0, rom_address0, rom_ce0}, 64'd0);
        check("rst_s_ready", {63'd0, s_ready}, 64'd0);
        reset = 1'b0;
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
        check("rst_no_done", 64'(done_cnt), 64'(dcnt0));
        aborted = 1'b1;
        break;
      end
      start   = extra_start && (t == 2);
      s_valid = (mode == 1) ? ($urandom_range(0, 9) < 7) : 1'b1;
      m_ready = (mode == 1) ? ($urandom_range(0, 9) < 7) :
                (mode == 2) ? !(t >= 3 && t <= 7) : 1'b1;
      case (gmode)
        0:       s_data = '0;
        1:       s_data = (acc_k < N) ? gtab[acc_k] : '0;
        default: case ($urandom_range(0, 3))
                   0:       s_data = 18'h1FFFF;
                   1:       s_data = 18'h20000;
                   default: s_data = DW'($urandom);
                 endcase
      endcase
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0; s_valid = 1'b0;
    if (!aborted) begin
      if (t >= 300) begin
        n_checks++; n_fail++;
        $display("FAIL run_timeout: got no done, expected done within 300 cycles");
      end
      check("done_count", 64'(done_cnt - dcnt0), 64'd1);
      check("busy_after_done", {63'd0, busy}, 64'd0);
      check("any_viol", {63'd0, any_viol}, {63'd0, viol_exp});
      check("queue_empty", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    for (int i = 0; i < 2**AW; i++) rom_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_m_valid", {63'd0, m_valid}, 64'd0);
    check("reset_m_data", {46'd0, m_data}, 64'd0);
    check("reset_flags", {60'd0, any_viol, m_neg, m_last, done}, 64'd0);
    check("reset_rom", {60'd0, rom_address0, rom_ce0}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // All-negative constants with g = 0.
    rom_mem[0] = 18'h38000; rom_mem[1] = 18'h26DE0; rom_mem[2] = 18'h3F000;
    rom_mem[3] = 18'h20001; rom_mem[4] = 18'h3FFFF; rom_mem[5] = 18'h2AAAA;
    do_run(0, 0, -1, 1'b0);
    check("viol_set", {63'd0, any_viol}, 64'd1);

    // Directed arithmetic corners: zero, -1, overflow both directions.
    rom_mem[0] = 18'h38000; rom_mem[1] = 18'h38000; rom_mem[2] = 18'h26DE0;
    rom_mem[3] = 18'h20000; rom_mem[4] = 18'h1FFFF; rom_mem[5] = 18'h00005;
    gtab[0] = 18'h38000; gtab[1] = 18'h3FFFF; gtab[2] = 18'h186A0;
    gtab[3] = 18'h1FFFF; gtab[4] = 18'h20000; gtab[5] = 18'h00000;
    do_run(0, 1, -1, 1'b0);

    do_run(2, 2, -1, 1'b0);
    do_run(0, 2, -1, 1'b1);
    do_run(0, 2, 3, 1'b0);
    do_run(0, 2, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) rom_mem[i] = DW'($urandom);
      do_run(1, 2, -1, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
